// File: rtl/demux1_to_4_32b.sv
`default_nettype none
// ============================================================================
//  Module      : demux1_to_4_32b
//  Description : Registered 1-to-4 demultiplexer for the 32-bit datapath.
//                A single valid/ready source is steered by a 2-bit select
//                into one of four one-entry output buffers. Each buffer has
//                its own valid/ready handshake toward its sink and its own
//                accepted-word counter, so a stalled sink only blocks words
//                addressed to it.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      rising-edge clock
//    rst        in   1      asynchronous, active-high reset
//    din        in   WIDTH  input data word
//    s          in   2      destination select (00->ch0 ... 11->ch3)
//    in_valid   in   1      source presents a word on din/s
//    in_ready   out  1      block can take the word this cycle
//    q0..q3     out  WIDTH  channel buffered data
//    v0..v3     out  1      channel buffer holds a word
//    r0..r3     in   1      sink takes the buffered word this cycle
//    cnt0..cnt3 out  CNT_W  words accepted into each channel (wraps)
// ============================================================================
module demux1_to_4_32b #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  input  logic             r0,
  input  logic             r1,
  input  logic             r2,
  input  logic             r3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  localparam int c_NCH = 4;

  // Sink-ready bits gathered into a vector so the select can index them.
  logic [c_NCH-1:0]       w_rdy;
  // Per-channel buffer-valid bits, collected from the channel slices.
  logic [c_NCH-1:0]       w_v;
  // Flattened per-channel data and counter buses.
  logic [c_NCH*WIDTH-1:0] w_q_flat;
  logic [c_NCH*CNT_W-1:0] w_cnt_flat;
  logic                   w_accept;

  assign w_rdy = {r3, r2, r1, r0};

  // The selected buffer can take a word when it is empty or is being drained
  // on this same edge. Deliberately independent of in_valid so the source
  // may look at in_ready before committing.
  assign in_ready = ~w_v[s] | w_rdy[s];
  assign w_accept = in_valid & in_ready;

  // --------------------------------------------------------------------------
  // One buffer slice per channel.
  // --------------------------------------------------------------------------
  generate
    for (genvar g_k = 0; g_k < c_NCH; g_k++) begin : g_ch
      localparam logic [1:0] c_SEL = 2'(g_k);

      logic             w_load;
      logic             w_xfer;
      logic             r_v;
      logic [WIDTH-1:0] r_q;
      logic [CNT_W-1:0] r_cnt;

      assign w_load = w_accept & (s == c_SEL);
      assign w_xfer = r_v & w_rdy[g_k];

      // A load wins over a transfer: when the sink drains and the source
      // refills on the same edge, the new word replaces the old one and the
      // valid bit stays high (pass-through at one word per cycle).
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v   <= 1'b0;
          r_q   <= '0;
          r_cnt <= '0;
        end else if (w_load) begin
          r_v   <= 1'b1;
          r_q   <= din;
          r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_xfer) begin
          // Data is left in place; only the valid flag drops.
          r_v   <= 1'b0;
        end
      end

      assign w_v[g_k]                       = r_v;
      assign w_q_flat[g_k*WIDTH +: WIDTH]   = r_q;
      assign w_cnt_flat[g_k*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output mapping
  // --------------------------------------------------------------------------
  assign v0 = w_v[0];
  assign v1 = w_v[1];
  assign v2 = w_v[2];
  assign v3 = w_v[3];

  assign q0 = w_q_flat[0*WIDTH +: WIDTH];
  assign q1 = w_q_flat[1*WIDTH +: WIDTH];
  assign q2 = w_q_flat[2*WIDTH +: WIDTH];
  assign q3 = w_q_flat[3*WIDTH +: WIDTH];

  assign cnt0 = w_cnt_flat[0*CNT_W +: CNT_W];
  assign cnt1 = w_cnt_flat[1*CNT_W +: CNT_W];
  assign cnt2 = w_cnt_flat[2*CNT_W +: CNT_W];
  assign cnt3 = w_cnt_flat[3*CNT_W +: CNT_W];

endmodule
`default_nettype wire
